image_pingpong_ctrl: RTL and testbench

IMAGE_PINGPONG_CTRL -- requirements
Module: image_pingpong_ctrl

---
 rtl/image_pingpong_ctrl.sv | 121 ++++++++++++
 tb/tb_image_pingpong_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_pingpong_ctrl.sv
// image_pingpong_ctrl: ping-pong bank controller between a 2D FFT producer and an image-bank consumer.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   cfg_last_addr        last entry index of a fill, latched on the first write into an EMPTY bank
//   in_valid / in_ready  producer handshake; mem_we = in_valid & in_ready
//   mem_we, mem_write_address, mem_select_block_we   write side of the bank memory
//   mem_read_address, mem_select_block_rd            read side of the bank memory
//   rd_start / rd_release / rd_busy                  consumer pass control
//   out_valid / out_last  read data valid (one-cycle RAM latency) and final entry of the pass
//   bank_full            bit b set while bank b is FULL
module image_pingpong_ctrl #(
    parameter int IMAGE_MEM_DEPTH_BITS = 13
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [IMAGE_MEM_DEPTH_BITS-1:0] cfg_last_addr,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            mem_we,
    output logic [IMAGE_MEM_DEPTH_BITS-1:0] mem_write_address,
    output logic                            mem_select_block_we,
    output logic [IMAGE_MEM_DEPTH_BITS-1:0] mem_read_address,
    output logic                            mem_select_block_rd,
    input  logic                            rd_start,
    input  logic                            rd_release,
    output logic                            rd_busy,
    output logic                            out_valid,
    output logic                            out_last,
    output logic [1:0]                      bank_full
);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

    bank_state_t                     r_state [2];
    logic [IMAGE_MEM_DEPTH_BITS-1:0] r_last_addr [2];
    logic                            r_wr_bank;
    logic                            r_rd_bank;
    logic [IMAGE_MEM_DEPTH_BITS-1:0] r_wr_ptr;
    logic [IMAGE_MEM_DEPTH_BITS-1:0] r_rd_ptr;
    logic                            r_rd_issue;
    logic                            r_out_valid;
    logic                            r_out_last;

    bank_state_t                     w_wr_state;
    bank_state_t                     w_rd_state;
    logic                            w_in_ready;
    logic                            w_we;
    logic [IMAGE_MEM_DEPTH_BITS-1:0] w_wr_last;
    logic [IMAGE_MEM_DEPTH_BITS-1:0] w_rd_last;
    logic                            w_rd_busy;
    logic                            w_start;
    logic                            w_release;

    always_comb begin
        w_wr_state = r_state[r_wr_bank];
        w_rd_state = r_state[r_rd_bank];
        w_in_ready = !reset && (w_wr_state != FULL);
        w_we       = in_valid && w_in_ready;
        // The first write into an EMPTY bank compares against the fresh cfg value
        w_wr_last  = (w_wr_state == EMPTY) ? cfg_last_addr : r_last_addr[r_wr_bank];
        w_rd_last  = r_last_addr[r_rd_bank];
        w_rd_busy  = r_rd_issue || r_out_valid;
        w_start    = rd_start && !w_rd_busy && (w_rd_state == FULL);
        // A start in the same cycle takes priority over a release
        w_release  = rd_release && !rd_start && !w_rd_busy && (w_rd_state == FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i]     <= EMPTY;
                r_last_addr[i] <= '0;
            end
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_issue  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_we) begin
                if (w_wr_state == EMPTY)
                    r_last_addr[r_wr_bank] <= cfg_last_addr;
                if (r_wr_ptr == w_wr_last) begin
                    r_state[r_wr_bank] <= FULL;
                    r_wr_ptr           <= '0;
                    r_wr_bank          <= ~r_wr_bank;
                end else begin
                    r_state[r_wr_bank] <= FILLING;
                    r_wr_ptr           <= r_wr_ptr + 1'b1;
                end
            end
            // A released bank is always FULL and the write bank never is, so these never collide
            if (w_release) begin
                r_state[r_rd_bank] <= EMPTY;
                r_rd_bank          <= ~r_rd_bank;
            end
            // Read data trails the address by one cycle
            r_out_valid <= r_rd_issue;
            r_out_last  <= r_rd_issue && (r_rd_ptr == w_rd_last);
            if (w_start) begin
                r_rd_issue <= 1'b1;
                r_rd_ptr   <= '0;
            end else if (r_rd_issue) begin
                r_rd_issue <= (r_rd_ptr != w_rd_last);
                r_rd_ptr   <= (r_rd_ptr == w_rd_last) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    assign in_ready            = w_in_ready;
    assign mem_we              = w_we;
    assign mem_write_address   = r_wr_ptr;
    assign mem_select_block_we = r_wr_bank;
    assign mem_read_address    = r_rd_ptr;
    assign mem_select_block_rd = r_rd_bank;
    assign rd_busy             = w_rd_busy;
    assign out_valid           = r_out_valid;
    assign out_last            = r_out_last;
    assign bank_full           = {r_state[1] == FULL, r_state[0] == FULL};
endmodule

// File: tb/tb_image_pingpong_ctrl.sv
// tb_image_pingpong_ctrl: directed self-checking bench for image_pingpong_ctrl.
module tb_image_pingpong_ctrl;
    localparam int DB = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DB-1:0] cfg_last_addr = '0;
    logic          in_valid = 1'b0;
    logic          rd_start = 1'b0;
    logic          rd_release = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [DB-1:0] mem_write_address;
    logic          mem_select_block_we;
    logic [DB-1:0] mem_read_address;
    logic          mem_select_block_rd;
    logic          rd_busy;
    logic          out_valid;
    logic          out_last;
    logic [1:0]    bank_full;
    int            n_tests = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    image_pingpong_ctrl #(.IMAGE_MEM_DEPTH_BITS(DB)) dut (
        .clk                 (clk),
        .reset               (reset),
        .cfg_last_addr       (cfg_last_addr),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .mem_we              (mem_we),
        .mem_write_address   (mem_write_address),
        .mem_select_block_we (mem_select_block_we),
        .mem_read_address    (mem_read_address),
        .mem_select_block_rd (mem_select_block_rd),
        .rd_start            (rd_start),
        .rd_release          (rd_release),
        .rd_busy             (rd_busy),
        .out_valid           (out_valid),
        .out_last            (out_last),
        .bank_full           (bank_full)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Cycle k after an accepted start at edge t (k=1 is cycle t+1) for an n-entry pass
    task automatic chk_rd(input string tag, input int k, input int n, input logic sel);
        check({tag, "_addr"}, 32'(mem_read_address), (k >= 1 && k <= n) ? k - 1 : 0);
        check({tag, "_valid"}, 32'(out_valid), 32'(k >= 2 && k <= n + 1));
        check({tag, "_last"}, 32'(out_last), 32'(k == n + 1));
        check({tag, "_busy"}, 32'(rd_busy), 32'(k >= 1 && k <= n + 1));
        check({tag, "_sel"}, 32'(mem_select_block_rd), 32'(sel));
    endtask

    initial begin
        in_valid = 1'b1;
        repeat (3) cyc();
        #1;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_busy", 32'(rd_busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_last", 32'(out_last), 0);
        check("rst_full", 32'(bank_full), 0);
        cyc();
        reset = 1'b0; in_valid = 1'b0; rd_start = 1'b1; rd_release = 1'b1;
        #1;
        check("ready_after_rst", 32'(in_ready), 1);
        check("idle_busy", 32'(rd_busy), 0);
        cyc();
        rd_start = 1'b0; rd_release = 1'b0;
        #1;
        check("nostart_busy", 32'(rd_busy), 0);
        check("nostart_full", 32'(bank_full), 0);
        cyc();
        #1;
        check("nostart_valid", 32'(out_valid), 0);
        // Fill bank 0 with 4 entries; later cfg values must be ignored
        for (int i = 0; i < 4; i++) begin
            cyc();
            in_valid = 1'b1; cfg_last_addr = (i == 0) ? DB'(3) : DB'(9);
            #1;
            check("fill_we", 32'(mem_we), 1);
            check("fill_addr", 32'(mem_write_address), 32'(i));
            check("fill_sel", 32'(mem_select_block_we), 0);
            check("fill_ready", 32'(in_ready), 1);
        end
        cyc();
        in_valid = 1'b0; cfg_last_addr = '0;
        #1;
        check("fill_full", 32'(bank_full), 1);
        check("fill_wrbank", 32'(mem_select_block_we), 1);
        check("fill_ready_after", 32'(in_ready), 1);
        check("fill_ptr_clr", 32'(mem_write_address), 0);
        // Pass 1 with an ignored start mid-pass and an ignored release on out_last
        cyc();
        rd_start = 1'b1;
        #1;
        check("p1_pre_busy", 32'(rd_busy), 0);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            rd_start = (k == 2); rd_release = (k == 5);
            #1;
            chk_rd("p1", k, 4, 1'b0);
        end
        cyc();
        rd_start = 1'b0; rd_release = 1'b0;
        #1;
        check("kept_full", 32'(bank_full), 1);
        check("no_extra_pass", 32'(rd_busy), 0);
        // Pass 2 on bank 0 while bank 1 fills with 8 entries
        cyc();
        rd_start = 1'b1; in_valid = 1'b1; cfg_last_addr = DB'(7);
        #1;
        check("ov_we0", 32'(mem_we), 1);
        check("ov_addr0", 32'(mem_write_address), 0);
        check("ov_sel0", 32'(mem_select_block_we), 1);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            rd_start = 1'b0; cfg_last_addr = '0;
            #1;
            chk_rd("p2", k, 4, 1'b0);
            check("ov_addr", 32'(mem_write_address), 32'(k));
            check("ov_we", 32'(mem_we), 1);
            check("ov_sel", 32'(mem_select_block_we), 1);
        end
        cyc();
        #1;
        check("bp_full", 32'(bank_full), 3);
        check("bp_ready", 32'(in_ready), 0);
        check("bp_we", 32'(mem_we), 0);
        check("bp_busy", 32'(rd_busy), 0);
        cyc();
        rd_release = 1'b1;
        #1;
        check("bp_ready_rel", 32'(in_ready), 0);
        cyc();
        rd_release = 1'b0; cfg_last_addr = DB'(1);
        #1;
        check("resume_ready", 32'(in_ready), 1);
        check("resume_we", 32'(mem_we), 1);
        check("resume_addr", 32'(mem_write_address), 0);
        check("resume_sel", 32'(mem_select_block_we), 0);
        check("resume_full", 32'(bank_full), 2);
        check("resume_rdsel", 32'(mem_select_block_rd), 1);
        cyc();
        cfg_last_addr = '0;
        #1;
        check("resume_addr1", 32'(mem_write_address), 1);
        check("resume_we1", 32'(mem_we), 1);
        cyc();
        in_valid = 1'b0;
        #1;
        check("both_full", 32'(bank_full), 3);
        check("both_ready", 32'(in_ready), 0);
        check("both_wrsel", 32'(mem_select_block_we), 1);
        // Pass on bank 1 with start and release together: the release is dropped
        cyc();
        rd_start = 1'b1; rd_release = 1'b1;
        #1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            rd_start = 1'b0; rd_release = 1'b0;
            #1;
            chk_rd("p3", k, 8, 1'b1);
        end
        check("start_beats_release", 32'(bank_full), 3);
        // Release bank 1, then release bank 0 while writing into bank 1
        cyc();
        rd_release = 1'b1;
        #1;
        cyc();
        in_valid = 1'b1; cfg_last_addr = DB'(2);
        #1;
        check("rw_full", 32'(bank_full), 1);
        check("rw_rdsel", 32'(mem_select_block_rd), 0);
        check("rw_we", 32'(mem_we), 1);
        check("rw_addr", 32'(mem_write_address), 0);
        check("rw_wrsel", 32'(mem_select_block_we), 1);
        cyc();
        rd_release = 1'b0; cfg_last_addr = '0;
        #1;
        check("rw_full2", 32'(bank_full), 0);
        check("rw_rdsel2", 32'(mem_select_block_rd), 1);
        check("rw_addr1", 32'(mem_write_address), 1);
        check("rw_we1", 32'(mem_we), 1);
        cyc();
        #1;
        check("rw_addr2", 32'(mem_write_address), 2);
        check("rw_we2", 32'(mem_we), 1);
        cyc();
        in_valid = 1'b0;
        #1;
        check("rw_full3", 32'(bank_full), 2);
        check("rw_wrsel3", 32'(mem_select_block_we), 0);
        // Reset in the third cycle of a pass
        cyc();
        rd_start = 1'b1;
        #1;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            rd_start = 1'b0;
            #1;
            chk_rd("p4", k, 3, 1'b1);
        end
        reset = 1'b1; in_valid = 1'b1;
        #1;
        check("mr_ready_now", 32'(in_ready), 0);
        check("mr_we_now", 32'(mem_we), 0);
        cyc();
        #1;
        check("mr_busy", 32'(rd_busy), 0);
        check("mr_valid", 32'(out_valid), 0);
        check("mr_last", 32'(out_last), 0);
        check("mr_full", 32'(bank_full), 0);
        check("mr_raddr", 32'(mem_read_address), 0);
        check("mr_ready", 32'(in_ready), 0);
        check("mr_we", 32'(mem_we), 0);
        check("mr_waddr", 32'(mem_write_address), 0);
        cyc();
        reset = 1'b0; cfg_last_addr = DB'(1);
        #1;
        check("pr_ready", 32'(in_ready), 1);
        check("pr_we", 32'(mem_we), 1);
        check("pr_addr", 32'(mem_write_address), 0);
        check("pr_sel", 32'(mem_select_block_we), 0);
        cyc();
        cfg_last_addr = '0;
        #1;
        check("pr_addr1", 32'(mem_write_address), 1);
        check("pr_we1", 32'(mem_we), 1);
        cyc();
        in_valid = 1'b0;
        #1;
        check("pr_full", 32'(bank_full), 1);
        check("pr_wrsel", 32'(mem_select_block_we), 1);
        check("pr_rdsel", 32'(mem_select_block_rd), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
